// File: rtl/fp_soma_control_unit.sv
`timescale 1ns/1ps
// Control unit for the floating-point addition datapath: sequences the
// normalization register through load, shift-left/right loop, a single
// rounding pass and renormalization, with a start/busy/done handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; far flag captured from diferenca_exp
// LOAD     | load adder result into normalization register
// CHECK    | inspect antes_virgula and choose next action
// SHIFT_R  | mantissa >> 1, exponent + 1
// SHIFT_L  | mantissa << 1, exponent - 1, shift counter + 1
// ROUND    | load round result (once per operation)
// DONE     | result valid on datapath, one-cycle done pulse
module fp_soma_control_unit #(
    parameter int N_exp  = 8,
    parameter int N_mant = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_exp-1:0] diferenca_exp,
    input  logic [1:0]       antes_virgula,
    output logic [1:0]       sel_mux_normalizer,
    output logic [1:0]       sel_normalizer,
    output logic             en_reg_norm,
    output logic             busy,
    output logic             done,
    output logic             zero_result
);

    localparam int            CW      = $clog2(N_mant + 2) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N_mant + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_SHIFT_R, S_SHIFT_L, S_ROUND, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            rounded, rounded_nx;
    logic            far, far_nx;
    logic            zero_nx;
    logic [N_exp-1:0] abs_diff;
    logic            far_det;

    // Magnitude of the exponent difference; -2^(N_exp-1) stays large as unsigned.
    assign abs_diff = diferenca_exp[N_exp-1] ? (~diferenca_exp + 1'b1) : diferenca_exp;
    assign far_det  = 32'(abs_diff) > 32'(N_mant + 1);

    // State and operation flags register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            rounded     <= 1'b0;
            far         <= 1'b0;
            zero_result <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            rounded     <= rounded_nx;
            far         <= far_nx;
            zero_result <= zero_nx;
        end
    end

    // Next-state and flag update logic.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        rounded_nx = rounded;
        far_nx     = far;
        zero_nx    = zero_result;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx   = S_LOAD;
                    cnt_nx     = '0;
                    rounded_nx = 1'b0;
                    zero_nx    = 1'b0;
                    far_nx     = far_det;
                end
            end
            S_LOAD: state_nx = S_CHECK;
            S_CHECK: begin
                if (antes_virgula[1]) begin
                    state_nx = S_SHIFT_R;
                end else if (antes_virgula[0]) begin
                    state_nx = (rounded || far) ? S_DONE : S_ROUND;
                end else if (cnt == CNT_MAX) begin
                    state_nx = S_DONE;
                    zero_nx  = 1'b1;
                end else begin
                    state_nx = S_SHIFT_L;
                end
            end
            S_SHIFT_R: state_nx = S_CHECK;
            S_SHIFT_L: begin
                state_nx = S_CHECK;
                if (cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
            end
            S_ROUND: begin
                state_nx   = S_CHECK;
                rounded_nx = 1'b1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        sel_mux_normalizer = 2'b00;
        sel_normalizer     = 2'b00;
        en_reg_norm        = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;
        case (state)
            S_IDLE:    busy = 1'b0;
            S_LOAD:    en_reg_norm = 1'b1;
            S_CHECK:   sel_mux_normalizer = 2'b01;
            S_SHIFT_R: begin
                sel_mux_normalizer = 2'b01;
                sel_normalizer     = 2'b01;
                en_reg_norm        = 1'b1;
            end
            S_SHIFT_L: begin
                sel_mux_normalizer = 2'b01;
                sel_normalizer     = 2'b10;
                en_reg_norm        = 1'b1;
            end
            S_ROUND: begin
                sel_mux_normalizer = 2'b10;
                en_reg_norm        = 1'b1;
            end
            S_DONE: begin
                sel_mux_normalizer = 2'b01;
                done               = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: doc/fp_soma_control_unit.md
Name: fp_soma_control_unit

Overview:
- Control unit (UC) FSM for the floating-point addition datapath.
- Consumes the datapath status signals: the exponent difference and the two integer bits of the adder result (`antes_virgula`).
- Drives the normalizer mux select, the normalizer operation select and the normalization-register load enable. Sequences load, normalize-shift loop, single rounding pass and renormalization.
- Provides a start/busy/done handshake to the surrounding FPU sequencer.

Parameters:
- N_exp, 8, exponent width; width of `diferenca_exp`.
- N_mant, 23, stored mantissa width. Maximum left-shift count is N_mant+1. The far-path threshold is also N_mant+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin one addition; sampled only in IDLE
- diferenca_exp  input  N_exp  exp_A - exp_B, two's complement; sampled in IDLE on start
- antes_virgula  input  2  bits [N_mant+1:N_mant] of the current normalizer input mantissa
- sel_mux_normalizer  output  2  00 = adder result, 01 = normalizer feedback, 10 = round result
- sel_normalizer  output  2  00 = pass, 01 = shift right (mant>>1, exp+1), 10 = shift left (mant<<1, exp-1)
- en_reg_norm  output  1  load enable for the datapath normalization register
- busy  output  1  high from the cycle after accepted start through DONE
- done  output  1  one-cycle pulse; result valid on the datapath this cycle
- zero_result  output  1  registered; valid while done=1; held until next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; sel_mux_normalizer=00, sel_normalizer=00, en_reg_norm=0, busy=0, done=0, zero_result=0; shift counter=0; rounded flag=0; far flag=0.
- All outputs are decoded from the registered state (Moore). Only next-state logic depends on inputs.
- IDLE: outputs 00/00/0, busy=0.
  - If start=1 at the edge: go to LOAD, clear counter/rounded/zero_result.
  - Set far = (|diferenca_exp| > N_mant+1), where |x| = (x[N_exp-1] ? ~x+1 : x).
  - start in any other state is ignored.
- LOAD (1 cycle): sel_mux=00, sel_norm=00, en_reg_norm=1 → CHECK.
- CHECK: sel_mux=01, sel_norm=00, en_reg_norm=0. Evaluate antes_virgula:
  - 1x → SHIFT_R.
  - 01 and (rounded or far) → DONE.
  - 01 otherwise → ROUND.
  - 00 and counter == N_mant+1 → DONE with zero_result set to 1.
  - 00 otherwise → SHIFT_L.
- SHIFT_R: sel_mux=01, sel_norm=01, en_reg_norm=1 → CHECK. Counter unchanged.
- SHIFT_L: sel_mux=01, sel_norm=10, en_reg_norm=1, counter+1 → CHECK.
- ROUND: sel_mux=10, sel_norm=00, en_reg_norm=1, rounded=1 → CHECK. Rounding executes at most once per operation. A post-round carry (1x) is handled by SHIFT_R, then CHECK → DONE.
- DONE: done=1, busy=1, selects 01/00, en_reg_norm=0 → IDLE.
- Counter width is clog2(N_mant+2)+1 and must never wrap; saturate at N_mant+1.
- Far path: ROUND is skipped and the smaller operand is treated as fully shifted out. SHIFT_R and SHIFT_L still apply.
- Minimum latency, start edge to done: 5 cycles (LOAD, CHECK, ROUND, CHECK, DONE). Far path: 3 cycles.
- Worst case (all-zero mantissa): 1 + 2·(N_mant+1) + 1 + 1 cycles = 51 for N_mant=23.
- Reset asserted mid-operation: immediate return to IDLE. No done pulse; all outputs at reset values.
- antes_virgula is X outside CHECK and must not affect state.

Test Plan:
- Normal path: diferenca_exp=0, antes_virgula=01 constant, start pulse at edge 0.
  - Required: LOAD@1 (en=1, mux=00), CHECK@2, ROUND@3 (mux=10, en=1), CHECK@4, done=1@5, busy low@6, zero_result=0.
- Right shift: antes_virgula=10 in first CHECK, 01 thereafter.
  - Required: exactly one SHIFT_R cycle (sel_norm=01, en=1), then ROUND, then done at cycle 7.
- Left shift: antes_virgula=00 for 3 CHECKs, then 01.
  - Required: three SHIFT_L cycles with sel_norm=10 and en=1, then ROUND, then done at cycle 11.
- Zero result: antes_virgula=00 always, N_mant=23.
  - Required: 24 SHIFT_L cycles, no ROUND, done at cycle 51 with zero_result=1.
- Far path: diferenca_exp=8'hE0 (−32), antes_virgula=01.
  - Required: LOAD, CHECK, done at cycle 3; sel_mux=10 never asserted.
- Robustness, two checks:
  - start held high during SHIFT_L: ignored, exactly one done.
  - rst_n low mid-SHIFT_L: outputs at reset values immediately; no done; next start behaves as in the normal-path scenario.
